// File: rtl/lbp_scan_ctrl_pkg.sv
// Shared types and constants for the LBP scan controller and its 3x3 window.
// Mode one-hot encodings are common with the external gray-address generator.
package lbp_scan_ctrl_pkg;

    localparam int IMG_DEFAULT = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_DRAIN,
        ST_WRITE,
        ST_FILL,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        FILL_RIGHT,
        FILL_DOWN,
        FILL_LEFT
    } fill_t;

    // Mode bus bit order is {fill_left, fill_down, fill_right, initialize}.
    localparam logic [3:0] MODE_INIT  = 4'b0001;
    localparam logic [3:0] MODE_RIGHT = 4'b0010;
    localparam logic [3:0] MODE_DOWN  = 4'b0100;
    localparam logic [3:0] MODE_LEFT  = 4'b1000;

    // Window slots are row-major 0..8; LBP bit i maps to neighbour NB_* = i.
    localparam int CENTRE = 4;
    localparam int NB_TL = 0, NB_T = 1, NB_TR = 2, NB_L = 3;
    localparam int NB_R  = 4, NB_BL = 5, NB_B = 6, NB_BR = 7;

    typedef struct packed {
        logic       vld;
        logic [3:0] slot;
    } tag_t;

    function automatic logic [3:0] mode_onehot(fill_t m);
        case (m)
            FILL_RIGHT: return MODE_RIGHT;
            FILL_DOWN:  return MODE_DOWN;
            FILL_LEFT:  return MODE_LEFT;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic int nb_slot(int b);
        return (b < CENTRE) ? b : b + 1;
    endfunction

    // Slot vacated by the entry shift that fill pixel k (1..3) lands in.
    function automatic logic [3:0] fill_slot(fill_t m, logic [3:0] k);
        case (m)
            FILL_RIGHT: return 4'(3 * int'(k) - 1);
            FILL_LEFT:  return 4'(3 * int'(k) - 3);
            FILL_DOWN:  return 4'(int'(k) + 5);
            default:    return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/lbp_window.sv
// 3x3 pixel window with directional shifts, a single slot write port and the LBP compare.
// Latency: shifts/writes take effect on the next edge; lbp is combinational from the registers.
// Backpressure: none; the controller sequences shifts and writes so they never collide.
module lbp_window
    import lbp_scan_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       shift_right,
    input  logic       shift_left,
    input  logic       shift_up,
    input  logic       wr_en,
    input  logic [3:0] wr_slot,
    input  logic [7:0] wr_dat,
    output logic [7:0] lbp
);

    logic [7:0] w [9];

    // shift_right means the centre moved right, so the left column falls out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 9; i++) w[i] <= '0;
        end else begin
            if (shift_right) begin
                for (int r = 0; r < 3; r++) begin
                    w[3*r]   <= w[3*r+1];
                    w[3*r+1] <= w[3*r+2];
                end
            end else if (shift_left) begin
                for (int r = 0; r < 3; r++) begin
                    w[3*r+2] <= w[3*r+1];
                    w[3*r+1] <= w[3*r];
                end
            end else if (shift_up) begin
                for (int i = 0; i < 6; i++) w[i] <= w[i+3];
            end
            if (wr_en) w[wr_slot] <= wr_dat;
        end
    end

    always_comb begin
        lbp = '0;
        for (int b = 0; b < 8; b++) lbp[b] = (w[nb_slot(b)] >= w[CENTRE]);
    end

endmodule

// File: rtl/lbp_scan_ctrl.sv
// Serpentine LBP scan controller: issues gray fetches, captures a 3x3 window, writes one code per centre.
// Latency: pixels return GRAY_LAT (initialize) or 1+GRAY_LAT (fill) cycles after issue; write follows drain.
// Backpressure: LBP_WRITE_STALL_EN adds lbp_ready and holds WRITE until it is high; otherwise writes are one cycle.
module lbp_scan_ctrl
    import lbp_scan_ctrl_pkg::*;
#(
    parameter int IMG      = IMG_DEFAULT,
    parameter int GRAY_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gray_ready,
`ifdef LBP_WRITE_STALL_EN
    input  logic        lbp_ready,
`endif
    input  logic [7:0]  gray_data,
    output logic        gray_req,
    output logic        initialize,
    output logic        fill_right,
    output logic        fill_down,
    output logic        fill_left,
    output logic        gray_addr_en,
    output logic [3:0]  cycle,
    output logic [13:0] lbp_addr,
    output logic        lbp_valid,
    output logic [7:0]  lbp_data,
    output logic        finish
);

    localparam int         DEPTH    = GRAY_LAT + 1;
    localparam logic [6:0] LAST_POS = 7'(IMG - 2);

    state_t     state, state_nxt;
    fill_t      fmode, fmode_nxt;
    logic [6:0] row, col, row_nxt, col_nxt;
    logic       dir, dir_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] mode_vec;
    logic       row_end, write_ok, tags_busy, init_issue;
    logic       shift_right, shift_left, shift_up;
    logic [7:0] win_lbp;
    tag_t       issue;
    tag_t       tag [DEPTH];

`ifdef LBP_WRITE_STALL_EN
    assign write_ok = lbp_ready;
`else
    assign write_ok = 1'b1;
`endif

    assign row_end    = dir ? (col == LAST_POS) : (col == 7'd1);
    assign init_issue = (state == ST_INIT);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        row_nxt      = row;
        col_nxt      = col;
        dir_nxt      = dir;
        fmode_nxt    = fmode;
        mode_vec     = '0;
        cycle        = '0;
        gray_addr_en = 1'b0;
        lbp_valid    = 1'b0;
        issue        = tag_t'(0);
        shift_right  = 1'b0;
        shift_left   = 1'b0;
        shift_up     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (gray_ready) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = 4'd1;
                end
            end
            ST_INIT: begin
                mode_vec   = MODE_INIT;
                cycle      = cnt;
                issue.vld  = 1'b1;
                issue.slot = cnt - 4'd1;
                cnt_nxt    = cnt + 4'd1;
                if (cnt == 4'd9) state_nxt = ST_DRAIN;
            end
            ST_FILL: begin
                mode_vec     = mode_onehot(fmode);
                cycle        = cnt;
                gray_addr_en = 1'b1;
                issue.vld    = 1'b1;
                issue.slot   = fill_slot(fmode, cnt);
                cnt_nxt      = cnt + 4'd1;
                if (cnt == 4'd3) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!tags_busy) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                lbp_valid = 1'b1;
                if (write_ok) begin
                    if (row_end && row == LAST_POS) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_FILL;
                        cnt_nxt   = 4'd1;
                        if (row_end) begin
                            row_nxt   = row + 7'd1;
                            dir_nxt   = !dir;
                            fmode_nxt = FILL_DOWN;
                            shift_up  = 1'b1;
                        end else if (dir) begin
                            col_nxt     = col + 7'd1;
                            fmode_nxt   = FILL_RIGHT;
                            shift_right = 1'b1;
                        end else begin
                            col_nxt    = col - 7'd1;
                            fmode_nxt  = FILL_LEFT;
                            shift_left = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            fmode <= FILL_RIGHT;
            row   <= 7'd1;
            col   <= 7'd1;
            dir   <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            fmode <= fmode_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
            dir   <= dir_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Initialize addresses are combinational, so their tags skip the generator-register stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) tag[i] <= tag_t'(0);
        end else begin
            tag[0] <= init_issue ? tag_t'(0) : issue;
            tag[1] <= init_issue ? issue : tag[0];
            for (int i = 2; i < DEPTH; i++) tag[i] <= tag[i-1];
        end
    end

    always_comb begin
        tags_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) tags_busy = tags_busy | tag[i].vld;
    end

    lbp_window u_window (
        .clk         (clk),
        .reset       (reset),
        .shift_right (shift_right),
        .shift_left  (shift_left),
        .shift_up    (shift_up),
        .wr_en       (tag[DEPTH-1].vld),
        .wr_slot     (tag[DEPTH-1].slot),
        .wr_dat      (gray_data),
        .lbp         (win_lbp)
    );

    assign {fill_left, fill_down, fill_right, initialize} = mode_vec;
    assign gray_req = (state == ST_INIT) || (state == ST_FILL);
    assign lbp_addr = {row, col};
    assign lbp_data = (state == ST_WRITE) ? win_lbp : 8'd0;
    assign finish   = (state == ST_DONE);

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Bench for lbp_scan_ctrl: two instances (8x8 image, GRAY_LAT=1 and 7x7 image, GRAY_LAT=3)
// fed by a behavioural gray-address generator and pixel memory.
module tb_lbp_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst1 = 1'b0, rst3 = 1'b0;
    logic ready1 = 1'b0, ready3 = 1'b0;
`ifdef LBP_WRITE_STALL_EN
    logic lrdy1 = 1'b1, lrdy3 = 1'b1;
`endif
    logic [7:0]  gd1, gd3;
    logic        d1_req, d1_init, d1_fr, d1_fd, d1_fl, d1_en, d1_vld, d1_fin;
    logic        d3_req, d3_init, d3_fr, d3_fd, d3_fl, d3_en, d3_vld, d3_fin;
    logic [3:0]  d1_cycle, d3_cycle;
    logic [13:0] d1_addr, d3_addr;
    logic [7:0]  d1_data, d3_data;

    lbp_scan_ctrl #(.IMG(8), .GRAY_LAT(1)) dut1 (
        .clk(clk), .reset(rst1), .gray_ready(ready1),
`ifdef LBP_WRITE_STALL_EN
        .lbp_ready(lrdy1),
`endif
        .gray_data(gd1), .gray_req(d1_req), .initialize(d1_init), .fill_right(d1_fr),
        .fill_down(d1_fd), .fill_left(d1_fl), .gray_addr_en(d1_en), .cycle(d1_cycle),
        .lbp_addr(d1_addr), .lbp_valid(d1_vld), .lbp_data(d1_data), .finish(d1_fin)
    );

    lbp_scan_ctrl #(.IMG(7), .GRAY_LAT(3)) dut3 (
        .clk(clk), .reset(rst3), .gray_ready(ready3),
`ifdef LBP_WRITE_STALL_EN
        .lbp_ready(lrdy3),
`endif
        .gray_data(gd3), .gray_req(d3_req), .initialize(d3_init), .fill_right(d3_fr),
        .fill_down(d3_fd), .fill_left(d3_fl), .gray_addr_en(d3_en), .cycle(d3_cycle),
        .lbp_addr(d3_addr), .lbp_valid(d3_vld), .lbp_data(d3_data), .finish(d3_fin)
    );

    logic [7:0] img [0:16383];

    function automatic logic [13:0] gen_addr(logic [3:0] modes, logic [3:0] k, logic [13:0] la);
        int r, c, kk, rr, cc;
        r = int'(la[13:7]); c = int'(la[6:0]); kk = int'(k);
        rr = r; cc = c;
        if (modes[0])      begin rr = r - 1 + (kk - 1) / 3; cc = c - 1 + (kk - 1) % 3; end
        else if (modes[1]) begin rr = r - 2 + kk; cc = c + 1; end
        else if (modes[2]) begin rr = r + 1; cc = c - 2 + kk; end
        else if (modes[3]) begin rr = r - 2 + kk; cc = c - 1; end
        return {7'(rr), 7'(cc)};
    endfunction

    // Generator + memory models; untagged cycles carry random junk on gray_data.
    logic [3:0]  m1, m3;
    logic [13:0] a1_reg = '0, a3_reg = '0;
    logic        a1_rvld = 1'b0, a3_rvld = 1'b0;
    logic [7:0]  p1 = '0;
    logic [7:0]  p3 [3];
    assign m1 = {d1_fl, d1_fd, d1_fr, d1_init};
    assign m3 = {d3_fl, d3_fd, d3_fr, d3_init};
    assign gd1 = p1;
    assign gd3 = p3[2];

    always @(posedge clk) begin
        if (d1_en) a1_reg <= gen_addr(m1, d1_cycle, d1_addr);
        a1_rvld <= d1_en;
        if (d1_init)      p1 <= img[gen_addr(m1, d1_cycle, d1_addr)];
        else if (a1_rvld) p1 <= img[a1_reg];
        else              p1 <= 8'($urandom);
    end

    always @(posedge clk) begin
        if (d3_en) a3_reg <= gen_addr(m3, d3_cycle, d3_addr);
        a3_rvld <= d3_en;
        if (d3_init)      p3[0] <= img[gen_addr(m3, d3_cycle, d3_addr)];
        else if (a3_rvld) p3[0] <= img[a3_reg];
        else              p3[0] <= 8'($urandom);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    logic sel = 1'b0;
    logic        s_req, s_en, s_vld, s_fin;
    logic [3:0]  s_modes, s_cycle;
    logic [13:0] s_addr;
    logic [7:0]  s_data;
    assign s_req   = sel ? d3_req   : d1_req;
    assign s_en    = sel ? d3_en    : d1_en;
    assign s_vld   = sel ? d3_vld   : d1_vld;
    assign s_fin   = sel ? d3_fin   : d1_fin;
    assign s_modes = sel ? m3       : m1;
    assign s_cycle = sel ? d3_cycle : d1_cycle;
    assign s_addr  = sel ? d3_addr  : d1_addr;
    assign s_data  = sel ? d3_data  : d1_data;

    logic [13:0] wa [$];
    logic [7:0]  wd [$];
    logic [13:0] exp_q [$];
    logic [2:0]  flog [$];
    logic [13:0] falog [$];
    int last_cyc, fin_cyc, req_after, excl_err;

    function automatic logic [7:0] gold(logic [13:0] a);
        logic [6:0] r, c;
        logic [7:0] ctr, res;
        logic [7:0] nb [8];
        r = a[13:7]; c = a[6:0];
        ctr   = img[{r, c}];
        nb[0] = img[{r - 7'd1, c - 7'd1}];
        nb[1] = img[{r - 7'd1, c}];
        nb[2] = img[{r - 7'd1, c + 7'd1}];
        nb[3] = img[{r, c - 7'd1}];
        nb[4] = img[{r, c + 7'd1}];
        nb[5] = img[{r + 7'd1, c - 7'd1}];
        nb[6] = img[{r + 7'd1, c}];
        nb[7] = img[{r + 7'd1, c + 7'd1}];
        for (int i = 0; i < 8; i++) res[i] = (nb[i] >= ctr);
        return res;
    endfunction

    task automatic build_order(input int n);
        int r, c;
        bit right;
        exp_q.delete();
        r = 1; c = 1; right = 1'b1;
        for (int i = 0; i < (n - 2) * (n - 2); i++) begin
            exp_q.push_back({7'(r), 7'(c)});
            if (right && c < n - 2)       c++;
            else if (!right && c > 1)     c--;
            else begin r++; right = !right; end
        end
    endtask

    task automatic reset_sel();
        @(negedge clk);
        if (sel) rst3 = 1'b0; else rst1 = 1'b0;
        repeat (2) @(negedge clk);
        if (sel) rst3 = 1'b1; else rst1 = 1'b1;
    endtask

    task automatic run_scan();
        wa.delete(); wd.delete(); flog.delete(); falog.delete();
        last_cyc = -1; fin_cyc = -1; req_after = 0; excl_err = 0;
        reset_sel();
        if (sel) ready3 = 1'b1; else ready1 = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (s_vld) begin wa.push_back(s_addr); wd.push_back(s_data); last_cyc = cyc; end
            if (s_fin && fin_cyc < 0) fin_cyc = cyc;
            if (s_fin && (s_req || s_modes != 4'd0 || s_en || s_vld)) req_after++;
            if ($countones(s_modes) > 1 || (s_modes == 4'd0 && s_cycle != 4'd0)) excl_err++;
            if (s_cycle == 4'd1 && s_modes[3:1] != 3'd0) begin
                flog.push_back(s_modes[3:1]);
                falog.push_back(s_addr);
            end
            if (s_fin && cyc > fin_cyc + 3) break;
            if (cyc == 30) begin ready1 = 1'b0; ready3 = 1'b0; end
        end
        ready1 = 1'b0; ready3 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({d1_req, m1, d1_en, d1_cycle, d1_vld, d1_data, d1_fin} !== 19'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {d1_req, m1, d1_en, d1_cycle, d1_vld, d1_data, d1_fin});
        end
        checks++;
        if (d1_addr !== 14'h0081) begin errors++; $display("FAIL reset_addr: got %h expected 0081", d1_addr); end
        rst1 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (d1_req !== 1'b0) begin errors++; $display("FAIL idle_no_ready: gray_req %b expected 0", d1_req); end
    endtask

    task automatic test_const_image();
        for (int a = 0; a < 16384; a++) img[a] = 8'h40;
        sel = 1'b0;
        build_order(8);
        run_scan();
        checks++;
        if (wa.size() != 36) begin errors++; $display("FAIL const_count: got %0d expected 36", wa.size()); end
        for (int i = 0; i < wa.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wa[i] !== exp_q[i]) begin errors++; $display("FAIL const_addr[%0d]: got %h expected %h", i, wa[i], exp_q[i]); end
            checks++;
            if (wd[i] !== 8'hFF) begin errors++; $display("FAIL const_data[%0d]: got %h expected ff", i, wd[i]); end
        end
        checks++;
        if (wa.size() == 0 || wa[wa.size()-1] !== 14'h0301) begin
            errors++; $display("FAIL const_last_addr: got %0d writes, expected last write at 0301", wa.size());
        end
        checks++;
        if (fin_cyc !== last_cyc + 1) begin errors++; $display("FAIL const_finish: finish at %0d last write at %0d", fin_cyc, last_cyc); end
        checks++;
        if (req_after !== 0) begin errors++; $display("FAIL const_done_quiet: %0d active cycles after finish, expected 0", req_after); end
        checks++;
        if (excl_err !== 0) begin errors++; $display("FAIL const_mode_excl: %0d violations expected 0", excl_err); end
    endtask

    task automatic test_row_turn();
        checks++;
        if (flog.size() < 7) begin
            errors++; $display("FAIL turn_log: got %0d fills expected at least 7", flog.size());
        end else begin
            checks++;
            if (flog[4] !== 3'b001 || falog[4] !== {7'd1, 7'd6}) begin
                errors++; $display("FAIL turn_last_right: mode %b addr %h expected 001 0086", flog[4], falog[4]);
            end
            checks++;
            if (flog[5] !== 3'b010 || falog[5] !== {7'd2, 7'd6}) begin
                errors++; $display("FAIL turn_down: mode %b addr %h expected 010 0106", flog[5], falog[5]);
            end
            checks++;
            if (flog[6] !== 3'b100 || falog[6] !== {7'd2, 7'd5}) begin
                errors++; $display("FAIL turn_left: mode %b addr %h expected 100 0105", flog[6], falog[6]);
            end
        end
    endtask

    task automatic test_col_image();
        for (int a = 0; a < 16384; a++) img[a] = 8'(a % 128);
        sel = 1'b0;
        build_order(8);
        run_scan();
        checks++;
        if (wa.size() != 36) begin errors++; $display("FAIL col_count: got %0d expected 36", wa.size()); end
        // Right-hand column is larger; T and B equal the centre so they set too.
        for (int i = 0; i < wa.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wa[i] !== exp_q[i] || wd[i] !== 8'hD6) begin
                errors++; $display("FAIL col_write[%0d]: got %h/%h expected %h/d6", i, wa[i], wd[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int n;
        sel = 1'b0;
        reset_sel();
        ready1 = 1'b1;
        n = 0;
        while (!d1_fr && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!d1_fr) begin errors++; $display("FAIL midfill_reach: fill_right %b after %0d cycles expected 1", d1_fr, n); end
        #2 rst1 = 1'b0;
        #1;
        checks++;
        if ({d1_req, m1, d1_en, d1_cycle, d1_vld, d1_data, d1_fin} !== 19'd0 || d1_addr !== 14'h0081) begin
            errors++; $display("FAIL midfill_async: outputs %h addr %h expected 0 0081", {d1_req, m1, d1_en, d1_cycle}, d1_addr);
        end
        ready1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        checks++;
        if (d1_init !== 1'b0 || d1_req !== 1'b0) begin errors++; $display("FAIL midfill_idle: initialize %b expected 0", d1_init); end
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        checks++;
        if (d1_init !== 1'b1 || d1_cycle !== 4'd1) begin
            errors++; $display("FAIL restart: initialize %b cycle %0d expected 1 1", d1_init, d1_cycle);
        end
        @(negedge clk);
        checks++;
        if (d1_init !== 1'b1 || d1_cycle !== 4'd2) begin
            errors++; $display("FAIL ready_drop_ignored: initialize %b cycle %0d expected 1 2", d1_init, d1_cycle);
        end
    endtask

    task automatic test_lat3_random();
        for (int a = 0; a < 16384; a++) img[a] = 8'($urandom);
        sel = 1'b1;
        build_order(7);
        run_scan();
        checks++;
        if (wa.size() != 25) begin errors++; $display("FAIL lat3_count: got %0d expected 25", wa.size()); end
        for (int i = 0; i < wa.size() && i < exp_q.size(); i++) begin
            checks++;
            if (wa[i] !== exp_q[i] || wd[i] !== gold(exp_q[i])) begin
                errors++; $display("FAIL lat3_write[%0d]: got %h/%h expected %h/%h", i, wa[i], wd[i], exp_q[i], gold(exp_q[i]));
            end
        end
        checks++;
        if (wa.size() == 0 || wa[wa.size()-1] !== 14'h0285) begin
            errors++; $display("FAIL lat3_last_addr: got %0d writes, expected last write at 0285", wa.size());
        end
        checks++;
        if (fin_cyc !== last_cyc + 1) begin errors++; $display("FAIL lat3_finish: finish at %0d last write at %0d", fin_cyc, last_cyc); end
        sel = 1'b0;
    endtask

`ifdef LBP_WRITE_STALL_EN
    task automatic test_stall();
        int n;
        logic [13:0] a0;
        logic [7:0]  d0;
        sel = 1'b0;
        lrdy1 = 1'b0;
        reset_sel();
        ready1 = 1'b1;
        n = 0;
        while (!d1_vld && n < 200) begin @(negedge clk); n++; end
        a0 = d1_addr; d0 = d1_data;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (d1_vld !== 1'b1 || d1_addr !== a0 || d1_data !== d0 || d1_req !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d]: vld %b addr %h data %h req %b", k, d1_vld, d1_addr, d1_data, d1_req);
            end
            if (k < 5) @(negedge clk);
        end
        lrdy1 = 1'b1;
        @(negedge clk);
        checks++;
        if (d1_vld !== 1'b0) begin errors++; $display("FAIL stall_release: lbp_valid %b expected 0", d1_vld); end
        ready1 = 1'b0;
    endtask
`endif

    initial begin
        p3[0] = '0; p3[1] = '0; p3[2] = '0;
        test_reset();
        test_const_image();
        test_row_turn();
        test_col_image();
        test_reset_mid_fill();
        test_lat3_random();
`ifdef LBP_WRITE_STALL_EN
        test_stall();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
